seq_mul_unit: RTL
=================

Name: seq_mul_unit

Overview:
- Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU) sitting beside the ALU in the EX stage.
- Drives operands into one instance of full_adder_32bit every iteration and consumes its sum/cout: radix-2 shift-and-add, one partial product per clock.
- Issued by the EX-stage control with a start/busy/done handshake; the pipeline stalls while busy.

Parameters:
- XLEN, 32, operand/result width; only 32 supported because the adder instance is fixed-width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when not busy
- op  input  2  00 MUL (low word), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high)
- rs1  input  32  multiplicand operand a
- rs2  input  32  multiplier operand b
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- result  output  32  selected product word, held until next accepted start

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled at any edge including mid-operation: state IDLE, busy=0, done=0, result=0, count=0, internal accumulator cleared; in-flight operation discarded, no done.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - latch op.
  - Signedness: a signed for MULH/MULHSU; b signed for MULH only.
  - Latch magnitudes |a|, |b|; neg_flag = sign(a) XOR sign(b), each sign counted only where that operand is signed.
  - acc_hi=0, mplier=|b|, count=0; busy=1; go RUN.
- RUN, edges E1..E32, one iteration each:
  - adder inputs a=acc_hi, b=(mplier[0] ? |a| : 0), cin=0.
  - {acc_hi, mplier} <= {cout, sum, mplier} >> 1, i.e. a 65-bit right shift.
  - count increments; at count==31 (32nd iteration, E32) go FIX.
- FIX, edge E33:
  - product P = {acc_hi, mplier} (64-bit); if neg_flag, P = ~P + 1 (64-bit wrap).
  - result = P[31:0] for MUL, else P[63:32].
  - done=1, busy=0; go IDLE.
- done is high for exactly one cycle, E33 to E34; latency is 33 clocks from the start edge.
- start is ignored while busy=1: no queuing, no error.
- Back-to-back: start high during the done cycle is accepted at E34.
- result holds its value across IDLE until the next FIX.
- op/rs1/rs2 changes during RUN have no effect; only the values latched at E0 are used.
- Arithmetic: all intermediate sums unsigned 33-bit; unsigned magnitudes cannot overflow 64 bits.
- Edge operands: |0x80000000| = 0x80000000 unsigned. MUL low word is identical for all signedness choices.

Optional Feature:
- Macro: SEQ_MUL_ZERO_BYPASS_EN.
- Defined: at a start edge where rs1==0 or rs2==0, skip RUN/FIX. Next edge: result=0, done=1, busy=0. busy is high for that single cycle; latency is 1 clock. Nonzero operands behave exactly as without the macro.
- Undefined: every operation takes 33 clocks, including zero operands.

Test Plan:
- Reset mid-run: assert rst at E10 -> next edge busy=0, done=0, result=0; no done pulse follows; a new start is accepted afterwards.
- MUL rs1=7, rs2=6 -> done exactly 33 cycles after the start edge, result=0x0000002A; busy high E0..E33.
- MULH rs1=0x80000000, rs2=0x80000000 -> result=0x40000000. MULH rs1=0xFFFFFFFF, rs2=0x00000001 -> result=0xFFFFFFFF.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result=0xFFFFFFFF. MULHU same operands -> result=0xFFFFFFFE. MUL same operands -> result=0x00000001.
- Handshake:
  - start re-pulsed at E5 with different operands -> ignored; first result 42 unchanged.
  - start held high during the done cycle -> second op accepted at E34; its done arrives at E67.
- Zero operand, MULHU rs1=0, rs2=0x12345678:
  - with SEQ_MUL_ZERO_BYPASS_EN, done 1 cycle after start, result=0.
  - without it, done 33 cycles after start, result=0.

Source files
------------

// File: rtl/seq_mul_unit.sv
// Radix-2 shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), one partial product per clock.
// Optional macro SEQ_MUL_ZERO_BYPASS_EN: zero operands finish in one clock instead of 33.

module full_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

module seq_mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t            state;
    state_t            state_next;
    logic [4:0]        count;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   acc_hi;
    logic              neg_flag;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              zero_op;
    logic [XLEN-1:0]   add_b;
    logic [XLEN-1:0]   add_sum;
    logic              add_cout;
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod;

    // Sign of an operand only matters where the opcode treats it as signed.
    assign a_neg = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1[XLEN-1];
    assign b_neg = (op == OP_MULH) && rs2[XLEN-1];
    assign abs_a = a_neg ? (~rs1 + 1'b1) : rs1;
    assign abs_b = b_neg ? (~rs2 + 1'b1) : rs2;

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    assign zero_op = (rs1 == '0) || (rs2 == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign add_b = mplier[0] ? mcand : '0;

    full_adder_32bit u_adder (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign prod_raw = {acc_hi, mplier};
    assign prod     = neg_flag ? (~prod_raw + 1'b1) : prod_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_op ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A bypassed zero operation enters FIX with a cleared accumulator, so FIX emits 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            op_q     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc_hi   <= '0;
            neg_flag <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        mcand    <= abs_a;
                        mplier   <= zero_op ? '0 : abs_b;
                        acc_hi   <= '0;
                        neg_flag <= zero_op ? 1'b0 : (a_neg ^ b_neg);
                        count    <= '0;
                    end
                end
                RUN: begin
                    {acc_hi, mplier} <= {add_cout, add_sum, mplier[XLEN-1:1]};
                    count            <= count + 5'd1;
                end
                FIX: begin
                    result <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
